// File: rtl/seven_seg_display_driver.sv
// seven_seg_display_driver
// Multiplexed 4-digit common-anode seven-segment driver. It has its own dwell
// prescaler, a 2-bit digit selector and a blanking window at the start of each
// dwell. Inputs are snapshotted once per frame. Every output is decoded from
// registered state only.
module seven_seg_display_driver #(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        base_clock,
    input  logic        RESETn,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        lzb_en,
    output logic [3:0]  scan_out,
    output logic [6:0]  seg_out,
    output logic        dp_out
);

    localparam int CNT_W = ($clog2(PRESCALE) < 1) ? 1 : $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       sel_reg;
    logic [15:0]      snap_digits_reg;
    logic [3:0]       snap_dp_reg;
    logic             snap_lzb_reg;

    logic [3:0] snap_digit [4];
    logic [3:0] digit_zero;
    logic [3:0] digit_blank;

    // BCD to active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash
    function automatic logic [6:0] decode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b0111111;
        endcase
        return seg;
    endfunction

    // Dwell counter, digit selector and once-per-frame input snapshot.
    // The snapshot edge is also the first edge after reset release.
    always_ff @(posedge base_clock or negedge RESETn) begin
        if (!RESETn) begin
            cnt_reg         <= '0;
            sel_reg         <= '0;
            snap_digits_reg <= '0;
            snap_dp_reg     <= '0;
            snap_lzb_reg    <= 1'b0;
        end else begin
            if (cnt_reg == CNT_MAX) begin
                cnt_reg <= '0;
                sel_reg <= sel_reg + 2'd1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (cnt_reg == '0 && sel_reg == 2'd0) begin
                snap_digits_reg <= digits_in;
                snap_dp_reg     <= dp_in;
                snap_lzb_reg    <= lzb_en;
            end
        end
    end

    // Split the snapshot into per-digit nibbles and flag the zero digits
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign snap_digit[gi] = snap_digits_reg[gi*4 +: 4];
            assign digit_zero[gi] = (snap_digits_reg[gi*4 +: 4] == 4'd0);
        end
    endgenerate

    // Leading-zero blanking: a digit is blanked only when it and every digit to its
    // left are zero. U1 always shows.
    always_comb begin
        digit_blank    = 4'b0000;
        digit_blank[3] = snap_lzb_reg & digit_zero[3];
        digit_blank[2] = digit_blank[3] & digit_zero[2];
        digit_blank[1] = digit_blank[2] & digit_zero[1];
    end

    // Output decode: all dark during the blank window, then the selected digit
    always_comb begin
        scan_out = 4'b1111;
        seg_out  = 7'b1111111;
        dp_out   = 1'b1;
        if (cnt_reg >= BLANK_LIM) begin
            scan_out = ~(4'b0001 << sel_reg);
            seg_out  = digit_blank[sel_reg] ? 7'b1111111 : decode(snap_digit[sel_reg]);
            dp_out   = ~snap_dp_reg[sel_reg];
        end
    end

endmodule

// File: tb/tb_seven_seg_display_driver.sv
// Testbench for seven_seg_display_driver (PRESCALE=8, BLANK_CYCLES=2).
// A behavioural model predicts every cycle's outputs into a scoreboard queue.
// Spot checks use constant values for the key patterns.
module tb_seven_seg_display_driver;

    localparam int PS = 8;
    localparam int BL = 2;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits;
    logic [3:0]  dp_req;
    logic        lzb;
    logic [3:0]  scan;
    logic [6:0]  seg;
    logic        dp;

    int total = 0;
    int bad   = 0;
    string phase = "init";

    // model state
    int         m_cnt, m_sel;
    logic [3:0] m_dig [4];
    logic [3:0] m_dp;
    logic       m_lzb;

    logic [11:0] exp_q [$];

    seven_seg_display_driver #(.PRESCALE(PS), .BLANK_CYCLES(BL)) dut (
        .base_clock(clk),
        .RESETn    (rst_n),
        .digits_in (digits),
        .dp_in     (dp_req),
        .lzb_en    (lzb),
        .scan_out  (scan),
        .seg_out   (seg),
        .dp_out    (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [11:0] obs, input logic [11:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b", tag, obs, want);
        end else begin
            $display("ok   %s {scan,seg,dp}=%b", tag, obs);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_sel = 0;
        for (int k = 0; k < 4; k++) m_dig[k] = 4'd0;
        m_dp  = 4'd0;
        m_lzb = 1'b0;
    endtask

    task automatic model_edge();
        if (m_cnt == 0 && m_sel == 0) begin
            for (int k = 0; k < 4; k++) m_dig[k] = digits[k*4 +: 4];
            m_dp  = dp_req;
            m_lzb = lzb;
        end
        if (m_cnt == PS - 1) begin
            m_cnt = 0;
            m_sel = (m_sel + 1) % 4;
        end else begin
            m_cnt = m_cnt + 1;
        end
    endtask

    function automatic logic [11:0] model_out();
        logic [3:0] sc;
        logic [6:0] sg;
        logic       blanked;
        if (m_cnt < BL) return 12'hFFF;
        sc = 4'b1111;
        sc[m_sel] = 1'b0;
        blanked = m_lzb && (m_sel != 0);
        for (int k = m_sel; k < 4; k++)
            if (m_dig[k] != 4'd0) blanked = 1'b0;
        sg = blanked ? 7'b1111111 : seg_of(m_dig[m_sel]);
        return {sc, sg, ~m_dp[m_sel]};
    endfunction

    // one clock: model follows the edge, prediction queued, DUT compared on negedge
    task automatic step();
        logic [11:0] e;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        exp_q.push_back(model_out());
        @(negedge clk);
        e = exp_q.pop_front();
        check_val(phase, {scan, seg, dp}, e);
    endtask

    task automatic goto(input int sel, input int cnt);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(m_sel == sel && m_cnt == cnt) && n < 40);
        if (!(m_sel == sel && m_cnt == cnt))
            check_val("goto_bound", 12'(m_sel * 16 + m_cnt), 12'(sel * 16 + cnt));
    endtask

    initial begin
        rst_n  = 1'b0;
        digits = 16'h0000;
        dp_req = 4'b0000;
        lzb    = 1'b0;
        model_reset();
        #3;
        check_val("reset_state", {scan, seg, dp}, 12'hFFF);
        @(negedge clk);
        phase = "in_reset";
        step();
        step();

        // basic scan order with 1234
        digits = 16'h1234;
        phase  = "scan_1234";
        rst_n  = 1'b1;
        #1;
        check_val("release_blank0", {scan, seg, dp}, 12'hFFF);
        step();
        check_val("release_blank1", {scan, seg, dp}, 12'hFFF);
        step();
        check_val("u1_shows_4", {scan, seg, dp}, {4'b1110, 7'b0011001, 1'b1});
        goto(1, 4);
        check_val("u2_shows_3", {scan, seg, dp}, {4'b1101, 7'b0110000, 1'b1});
        goto(2, 7);
        check_val("u3_shows_2", {scan, seg, dp}, {4'b1011, 7'b0100100, 1'b1});
        goto(3, 7);
        check_val("u4_shows_1", {scan, seg, dp}, {4'b0111, 7'b1111001, 1'b1});
        goto(0, 1);
        check_val("frame_wrap_blank", {scan, seg, dp}, 12'hFFF);
        goto(0, 4);
        check_val("u1_repeat", {scan, seg, dp}, {4'b1110, 7'b0011001, 1'b1});

        // leading-zero blanking
        digits = 16'h0005;
        lzb    = 1'b1;
        phase  = "lzb_on";
        goto(0, 1);
        goto(1, 4);
        check_val("lzb_u2_blank", {scan, seg, dp}, {4'b1101, 7'b1111111, 1'b1});
        goto(3, 4);
        check_val("lzb_u4_blank", {scan, seg, dp}, {4'b0111, 7'b1111111, 1'b1});
        goto(0, 4);
        check_val("lzb_u1_5", {scan, seg, dp}, {4'b1110, 7'b0010010, 1'b1});
        lzb   = 1'b0;
        phase = "lzb_off";
        goto(0, 1);
        goto(2, 4);
        check_val("nolzb_u3_0", {scan, seg, dp}, {4'b1011, 7'b1000000, 1'b1});
        goto(3, 4);
        check_val("nolzb_u4_0", {scan, seg, dp}, {4'b0111, 7'b1000000, 1'b1});

        // mid-frame input change takes effect only at the next frame
        digits = 16'h1111;
        phase  = "midframe";
        goto(0, 1);
        goto(2, 4);
        digits = 16'h9999;
        step();
        check_val("mid_u3_still_1", {scan, seg, dp}, {4'b1011, 7'b1111001, 1'b1});
        goto(3, 4);
        check_val("mid_u4_still_1", {scan, seg, dp}, {4'b0111, 7'b1111001, 1'b1});
        goto(0, 4);
        check_val("next_u1_9", {scan, seg, dp}, {4'b1110, 7'b0010000, 1'b1});

        // decimal point on U3 only
        dp_req = 4'b0100;
        phase  = "dp";
        goto(0, 1);
        goto(2, 1);
        check_val("dp_in_blank", {scan, seg, dp}, 12'hFFF);
        goto(2, 4);
        check_val("dp_u3_on", {scan, seg, dp}, {4'b1011, 7'b0010000, 1'b0});
        goto(3, 4);
        check_val("dp_u4_off", {scan, seg, dp}, {4'b0111, 7'b0010000, 1'b1});

        // dash codes, never blanked
        digits = 16'hABCF;
        dp_req = 4'b0000;
        lzb    = 1'b1;
        phase  = "dash";
        goto(0, 1);
        goto(3, 4);
        check_val("dash_u4", {scan, seg, dp}, {4'b0111, 7'b0111111, 1'b1});
        goto(1, 4);
        check_val("dash_u2", {scan, seg, dp}, {4'b1101, 7'b0111111, 1'b1});

        // asynchronous reset while U2 is enabled
        phase = "async_rst";
        rst_n = 1'b0;
        #1;
        check_val("async_rst_now", {scan, seg, dp}, 12'hFFF);
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        phase = "after_rst";
        #1;
        check_val("after_rst_blank0", {scan, seg, dp}, 12'hFFF);
        step();
        check_val("after_rst_blank1", {scan, seg, dp}, 12'hFFF);
        step();
        check_val("after_rst_u1", {scan, seg, dp}, {4'b1110, 7'b0111111, 1'b1});
        goto(0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_display_driver.md
Name: seven_seg_display_driver

Overview:
- Drives a 4-digit, common-anode, multiplexed seven-segment display from four BCD digits, e.g. the counter60 minutes:seconds value.
- Contains its own scan-rate prescaler, a 2-bit digit selector and an anti-ghosting blank window.
- Snapshots its inputs once per frame so the display never shows a digit that changed mid-frame.
- Also contains BCD-to-segment decode with optional leading-zero blanking.
- Sits between the counter datapath and the board pins. It produces the active-low digit enables and the segment lines together, so enables and segment data are always consistent.

Parameters:
- PRESCALE, 50000: base_clock cycles each digit is held (dwell). Must be at least 2.
- BLANK_CYCLES, 16: cycles at the start of each dwell during which all digits are disabled. Range is 1 to PRESCALE-1.

Ports:
- base_clock, input, 1: system clock.
- RESETn, input, 1: asynchronous, active-low reset.
- digits_in, input, 16: four BCD digits. [3:0]=U1 (rightmost), [7:4]=U2, [11:8]=U3, [15:12]=U4 (leftmost).
- dp_in, input, 4: decimal-point request per digit, active high. Bit k maps to digit k.
- lzb_en, input, 1: enables leading-zero blanking.
- scan_out, output, 4: digit enables, active low. 4'b1110 selects U1 … 4'b0111 selects U4.
- seg_out, output, 7: segment lines {g,f,e,d,c,b,a}, active low.
- dp_out, output, 1: decimal-point segment, active low.

Behaviour:
- Reset (asynchronous, RESETn=0):
  - dwell counter cnt=0, sel=0.
  - Snapshot registers (digits, dp, lzb) cleared to 0.
  - scan_out=4'b1111, seg_out=7'b1111111, dp_out=1.
- cnt counts 0..PRESCALE-1 and wraps to 0. Width is $clog2(PRESCALE), minimum 1.
- sel increments (mod 4) on the edge where cnt==PRESCALE-1.
- Frame length is 4*PRESCALE cycles. Order is U1, U2, U3, U4, then U1 again.
- Snapshot: on every rising edge where cnt==0 and sel==0, digits_in, dp_in and lzb_en are captured. The captured values are used for the entire following frame. Input changes at any other time have no effect until the next frame start.
- Outputs are decoded from registered state (cnt, sel, snapshot) only. No input reaches an output combinationally.
- While cnt<BLANK_CYCLES:
  - scan_out=4'b1111, seg_out=7'b1111111, dp_out=1.
- While cnt>=BLANK_CYCLES:
  - scan_out = ~(4'b0001<<sel).
  - seg_out = decode(snapshot digit[sel]).
  - dp_out = ~snap_dp[sel].
- Decode (active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Codes 10–15 display a dash: 0111111.
- Leading-zero blanking applies when snap_lzb=1:
  - U4 is blanked if its value is 0.
  - U3 is blanked if U4 and U3 are both 0.
  - U2 is blanked if U4, U3 and U2 are all 0.
  - U1 is never blanked.
  - A blanked digit drives seg_out=7'b1111111. Its scan_out and dp_out behave as normal.
  - A dash code (10–15) counts as non-zero.
- Reset asserted mid-frame forces the reset values immediately. After release, the first edge is a frame start: a snapshot is taken and a blank window runs.

Test Plan:
- PRESCALE=8, BLANK_CYCLES=2. Reset, then hold digits_in=16'h1234, dp_in=0, lzb_en=0.
  - In each 8-cycle dwell, expect scan_out=1111 for 2 cycles, then 6 cycles of the selected digit.
  - Sequence: U1 shows 4 (0011001), U2 shows 3 (0110000), U3 shows 2 (0100100), U4 shows 1 (1111001).
  - After 32 cycles the sequence repeats from U1.
- Set digits_in=16'h0005, lzb_en=1.
  - U4, U3 and U2 drive seg_out=1111111 while enabled.
  - U1 drives 0010010.
  - With lzb_en=0, the same input shows 0 (1000000) on U4, U3 and U2.
- Change digits_in from 16'h1111 to 16'h9999 while sel=2.
  - U3 and U4 still show 1 in the current frame.
  - All digits show 9 from the next frame.
- dp_in=4'b0100: dp_out=0 only during U3's enabled window; otherwise 1.
- digits_in=16'hABCF: every digit shows dash (0111111).
  - With lzb_en=1, no digit is blanked.
- Assert RESETn=0 mid-dwell while U2 is enabled.
  - Outputs go to all 1 in the same cycle, without waiting for a clock edge.
  - After release: 2 blank cycles, then U1.
